lenet_core: RTL and testbench
=============================

// Module: lenet_core
// PURPOSE
//  Self-contained, LeNet-style inference datapath: conv 3x3 -> ReLU -> maxpool 2x2 -> FC -> scalar.
//  No data inputs; the input image is generated internally into a feature RAM after reset.
//  Top-level compute block of the CNN test design; finalresult is the only observable output.
//  Single clock domain, run/pause via enable.
// PARAMETERS
//  INPUT_NUM_MEM          1   number of input feature RAM banks (only 1 supported)
//  DATA_WIDTH             16  signed two's-complement data width of pixels, weights, result
//  IN_FEATURE_ADDR_WIDTH  10  feature RAM address width (1024 words; 64 used)
//  IMG                    8   input image side (IMG x IMG); conv map (IMG-2)^2, pooled ((IMG-2)/2)^2
//  KW                     1   conv kernel weight (all 9 taps equal, signed)
//  FCW                    1   fully-connected weight (all taps equal, signed)
// PORTS
//  clock        in   1           rising-edge clock
//  reset        in   1           synchronous, active-low reset
//  enable       in   1           1 = advance FSM/datapath; 0 = freeze all state
//  finalresult  out  DATA_WIDTH  signed network output; 0 until computation completes
// BEHAVIOUR
//  - Reset (reset==0 at a clock edge): FSM->IDLE, all counters/accumulators 0, finalresult=0.
//    Reset dominates enable; reset mid-run aborts and restarts from IDLE when released.
//  - enable==0: no state, RAM, or output changes (pause). Resumes seamlessly when enable returns to 1.
//  - FSM: IDLE -> LOAD -> CONV -> POOL -> FC -> DONE. IDLE leaves on first enabled cycle.
//  - LOAD: writes x[r][c] = r + c (r,c in 0..IMG-1), one word/cycle, addr = r*IMG + c.
//  - CONV: conv[r][c] = sum_{i,j in 0..2} KW * x[r+i][c+j], r,c in 0..IMG-3.
//    One MAC per cycle; 32-bit signed accumulator.
//    Result saturated to signed DATA_WIDTH range, then ReLU (negative -> 0), stored in map RAM.
//  - POOL: p[a][b] = max of conv[2a..2a+1][2b..2b+1], a,b in 0..(IMG-2)/2-1.
//  - FC: acc = sum over all p of FCW * p (32-bit signed).
//    finalresult <= sat16(acc) on entry to DONE.
//  - DONE: finalresult held constant until reset; further enable has no effect.
//  - Total enabled-cycle latency IDLE->DONE is deterministic and <= 600 cycles for IMG=8.
//  - Saturation: >32767 -> 32767, < -32768 -> -32768 (for DATA_WIDTH=16).
//  - Products are DATA_WIDTH x DATA_WIDTH signed -> 2*DATA_WIDTH. No wrap-around anywhere.
// TESTING
//  1 Defaults; reset low 2 cycles, enable=1, wait 1000 cycles -> finalresult = 648 (0x0288).
//  2 During run, check finalresult = 0 before DONE.
//    Hold enable=0 for 200 mid-run cycles -> final 648, reached exactly 200 cycles later than scenario 1.
//  3 KW=-1 -> all conv outputs negative, ReLU -> 0 -> finalresult = 0.
//  4 KW=1000 -> conv and pooled values saturate to 32767; FC = 294903 -> finalresult = 32767.
//  5 Assert reset mid-CONV -> finalresult 0 next cycle.
//    Release reset, keep enable=1 -> finalresult = 648 again.
//  6 Reset held low with enable=1 for 100 cycles -> finalresult stays 0 and the FSM stays in IDLE.

Source files
------------

// File: rtl/lenet_core.sv
// LeNet-style datapath: self-generated 8x8 image -> 3x3 conv -> ReLU -> 2x2 maxpool -> FC -> saturated scalar.
// Latency: 434 enabled cycles from IDLE to DONE at IMG=8; enable=0 freezes every register and RAM.
module lenet_core #(
  parameter int INPUT_NUM_MEM         = 1,
  parameter int DATA_WIDTH            = 16,
  parameter int IN_FEATURE_ADDR_WIDTH = 10,
  parameter int IMG                   = 8,
  parameter int KW                    = 1,
  parameter int FCW                   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] finalresult
);

  localparam int ACC_W      = 32;
  localparam int CN         = IMG - 2;
  localparam int PN         = CN / 2;
  localparam int CW         = $clog2(IMG);
  localparam int AW         = IN_FEATURE_ADDR_WIDTH;
  localparam int MAW        = $clog2(CN * CN);
  localparam int PAW        = $clog2(PN * PN);
  localparam int FEAT_WORDS = INPUT_NUM_MEM << AW;

  localparam logic signed [DATA_WIDTH-1:0] KW_S  = DATA_WIDTH'(KW);
  localparam logic signed [DATA_WIDTH-1:0] FCW_S = DATA_WIDTH'(FCW);
  localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] DMAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] DMIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_POOL, S_FC, S_DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] cnt_r, cnt_c, lim;
  logic [1:0]    ti, tj, tap_lim;
  logic          tap_end, tap_first, cell_end, cell_adv;

  logic signed [ACC_W-1:0]        acc, acc_sum;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]   mul_w, mul_x, feat_rd, map_rd, pool_rd;
  logic signed [DATA_WIDTH-1:0]   conv_sat, conv_out, pmax, pool_max_d;

  logic [DATA_WIDTH-1:0] feat_ram [FEAT_WORDS];
  logic [DATA_WIDTH-1:0] map_ram  [CN*CN];
  logic [DATA_WIDTH-1:0] pool_ram [PN*PN];

  logic [AW-1:0]  feat_waddr, feat_raddr;
  logic [MAW-1:0] map_waddr, map_raddr;
  logic [PAW-1:0] pool_addr;

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? AMIN : AMAX;
    return s[ACC_W-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_dw(input logic signed [ACC_W-1:0] v);
    if (v > DMAX) return DMAX[DATA_WIDTH-1:0];
    if (v < DMIN) return DMIN[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
  endfunction

  // Row/column counters are shared by every phase; only the wrap limit changes.
  always_comb begin
    lim     = CW'(PN - 1);
    tap_lim = 2'd1;
    case (state_q)
      S_LOAD: lim = CW'(IMG - 1);
      S_CONV: begin
        lim     = CW'(CN - 1);
        tap_lim = 2'd2;
      end
      default: ;
    endcase
  end

  assign tap_end   = (ti == tap_lim) && (tj == tap_lim);
  assign tap_first = (ti == 2'd0) && (tj == 2'd0);
  assign cell_end  = (cnt_r == lim) && (cnt_c == lim);
  assign cell_adv  = (state_q == S_LOAD) || (state_q == S_FC) ||
                     (((state_q == S_CONV) || (state_q == S_POOL)) && tap_end);

  assign feat_waddr = AW'(int'(cnt_r) * IMG + int'(cnt_c));
  assign feat_raddr = AW'((int'(cnt_r) + int'(ti)) * IMG + int'(cnt_c) + int'(tj));
  assign map_waddr  = MAW'(int'(cnt_r) * CN + int'(cnt_c));
  assign map_raddr  = MAW'((2 * int'(cnt_r) + int'(ti)) * CN + 2 * int'(cnt_c) + int'(tj));
  assign pool_addr  = PAW'(int'(cnt_r) * PN + int'(cnt_c));

  assign feat_rd = feat_ram[feat_raddr];
  assign map_rd  = map_ram[map_raddr];
  assign pool_rd = pool_ram[pool_addr];

  // One multiplier serves both the conv MACs and the FC MACs.
  always_comb begin
    mul_w      = (state_q == S_FC) ? FCW_S : KW_S;
    mul_x      = (state_q == S_FC) ? pool_rd : feat_rd;
    prod       = mul_w * mul_x;
    acc_sum    = sat_add(acc, ACC_W'(prod));
    conv_sat   = sat_dw(acc_sum);
    conv_out   = conv_sat[DATA_WIDTH-1] ? '0 : conv_sat;
    pool_max_d = (map_rd > pmax) ? map_rd : pmax;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: if (cell_end) state_d = S_CONV;
      S_CONV: if (tap_end && cell_end) state_d = S_POOL;
      S_POOL: if (tap_end && cell_end) state_d = S_FC;
      S_FC:   if (cell_end) state_d = S_DONE;
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset)      state_q <= S_IDLE;
    else if (enable) state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_r       <= '0;
      cnt_c       <= '0;
      ti          <= '0;
      tj          <= '0;
      acc         <= '0;
      pmax        <= '0;
      finalresult <= '0;
    end else if (enable) begin
      if ((state_q == S_CONV) || (state_q == S_POOL)) begin
        if (tj == tap_lim) begin
          tj <= '0;
          ti <= (ti == tap_lim) ? 2'd0 : ti + 2'd1;
        end else begin
          tj <= tj + 2'd1;
        end
      end
      if (cell_adv) begin
        if (cnt_c == lim) begin
          cnt_c <= '0;
          cnt_r <= (cnt_r == lim) ? '0 : cnt_r + 1'b1;
        end else begin
          cnt_c <= cnt_c + 1'b1;
        end
      end
      if (state_q == S_CONV) acc <= tap_end ? '0 : acc_sum;
      if (state_q == S_POOL) pmax <= tap_first ? map_rd : pool_max_d;
      if (state_q == S_FC) begin
        acc <= cell_end ? '0 : acc_sum;
        if (cell_end) finalresult <= sat_dw(acc_sum);
      end
    end
  end

  // RAMs carry no reset; every word is rewritten before it is read in a run.
  always_ff @(posedge clock) begin
    if (reset && enable) begin
      if (state_q == S_LOAD)
        feat_ram[feat_waddr] <= DATA_WIDTH'(int'(cnt_r) + int'(cnt_c));
      if ((state_q == S_CONV) && tap_end)
        map_ram[map_waddr] <= conv_out;
      if ((state_q == S_POOL) && tap_end)
        pool_ram[pool_addr] <= pool_max_d;
    end
  end

endmodule

// File: tb/tb_lenet_core.sv
// Bench for lenet_core: six parameterisations against an array-based reference of the network.
module tb_lenet_core;

  localparam int NI  = 6;
  localparam int IMG = 8;
  localparam int KWS  [NI] = '{1, -1, 1000, 1, 2,   1};
  localparam int FCWS [NI] = '{1,  1,    1, -1, 100, -100};

  typedef struct {
    int kw;
    int fcw;
    int exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset, enable;
  logic [NI-1:0][15:0] res;
  vec_t tbl [NI];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  lenet_core #(.KW(KWS[0]), .FCW(FCWS[0])) u0 (.clock(clock), .reset(reset), .enable(enable), .finalresult(res[0]));
  lenet_core #(.KW(KWS[1]), .FCW(FCWS[1])) u1 (.clock(clock), .reset(reset), .enable(enable), .finalresult(res[1]));
  lenet_core #(.KW(KWS[2]), .FCW(FCWS[2])) u2 (.clock(clock), .reset(reset), .enable(enable), .finalresult(res[2]));
  lenet_core #(.KW(KWS[3]), .FCW(FCWS[3])) u3 (.clock(clock), .reset(reset), .enable(enable), .finalresult(res[3]));
  lenet_core #(.KW(KWS[4]), .FCW(FCWS[4])) u4 (.clock(clock), .reset(reset), .enable(enable), .finalresult(res[4]));
  lenet_core #(.KW(KWS[5]), .FCW(FCWS[5])) u5 (.clock(clock), .reset(reset), .enable(enable), .finalresult(res[5]));

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int ref_final(input int kw, input int fcw);
    int x [IMG][IMG];
    int cv [IMG-2][IMG-2];
    longint acc;
    longint fc;
    int p, v;
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++) x[r][c] = r + c;
    for (int r = 0; r < IMG-2; r++)
      for (int c = 0; c < IMG-2; c++) begin
        acc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) acc += longint'(kw) * x[r+i][c+j];
        v = sat16(acc);
        cv[r][c] = (v < 0) ? 0 : v;
      end
    fc = 0;
    for (int a = 0; a < (IMG-2)/2; a++)
      for (int b = 0; b < (IMG-2)/2; b++) begin
        p = cv[2*a][2*b];
        if (cv[2*a][2*b+1] > p) p = cv[2*a][2*b+1];
        if (cv[2*a+1][2*b] > p) p = cv[2*a+1][2*b];
        if (cv[2*a+1][2*b+1] > p) p = cv[2*a+1][2*b+1];
        fc += longint'(fcw) * p;
      end
    return sat16(fc);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_table(input string tag);
    for (int k = 0; k < NI; k++)
      check($sformatf("%s[%0d] kw=%0d fcw=%0d", tag, k, tbl[k].kw, tbl[k].fcw),
            int'($signed(res[k])), tbl[k].exp);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < NI; k++) check($sformatf("%s[%0d]", tag, k), int'($signed(res[k])), 0);
  endtask

  // Runs from a released reset until instance 0 shows a result; pct>0 randomises enable.
  task automatic run_measure(input int budget, input int pause_at, input int pause_len, input int pct,
                             output int lat_tot, output int lat_en, output int zero_ok);
    int en_cnt;
    bit en_edge;
    en_cnt = 0;
    lat_tot = -1;
    lat_en = -1;
    zero_ok = 1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (pct > 0) enable = ($urandom_range(0, 99) < pct);
      else enable = !((cyc > pause_at) && (cyc <= pause_at + pause_len));
      en_edge = enable && reset;
      tick();
      if (en_edge) en_cnt++;
      if (res[0] != 16'd0) begin
        lat_tot = cyc;
        lat_en = en_cnt;
        break;
      end
      if (res != '0) zero_ok = 0;
    end
    enable = 1'b1;
  endtask

  initial begin
    int l0, lt, le, z, ok;
    logic [NI-1:0][15:0] snap;
    int pcts [3];

    for (int k = 0; k < NI; k++) begin
      tbl[k].kw  = KWS[k];
      tbl[k].fcw = FCWS[k];
      tbl[k].exp = ref_final(KWS[k], FCWS[k]);
    end

    reset = 1'b0;
    enable = 1'b1;
    repeat (2) tick();
    check_all_zero("reset_state");

    reset = 1'b1;
    run_measure(1000, 0, 0, 0, l0, le, z);
    check("latency_within_600", int'(l0 > 0 && l0 <= 600), 1);
    check("zero_before_done_s1", z, 1);
    check_table("final_s1");

    snap = res;
    ok = 1;
    for (int i = 0; i < 60; i++) begin
      enable = $urandom_range(0, 1);
      tick();
      if (res != snap) ok = 0;
    end
    check("done_holds", ok, 1);

    enable = 1'b1;
    reset = 1'b0;
    tick();
    check_all_zero("reset_clears_done");
    ok = 1;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (res != '0) ok = 0;
    end
    check("zero_while_reset_held", ok, 1);
    reset = 1'b1;
    run_measure(1000, 0, 0, 0, lt, le, z);
    check("idle_held_in_reset_latency", lt, l0);
    check("final_after_long_reset", int'($signed(res[0])), tbl[0].exp);

    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    run_measure(1500, 100, 200, 0, lt, le, z);
    check("pause_total_latency", lt, l0 + 200);
    check("pause_enabled_latency", le, l0);
    check("zero_before_done_pause", z, 1);
    check_table("final_pause");

    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    ok = 1;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (res != '0) ok = 0;
    end
    check("zero_mid_conv", ok, 1);
    reset = 1'b0;
    tick();
    check_all_zero("reset_mid_conv");
    reset = 1'b1;
    run_measure(1000, 0, 0, 0, lt, le, z);
    check("restart_latency", lt, l0);
    check_table("final_restart");

    pcts = '{50, 75, 90};
    for (int t = 0; t < 3; t++) begin
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      run_measure(3000, 0, 0, pcts[t], lt, le, z);
      check($sformatf("rand%0d_enabled_latency", t), le, l0);
      check($sformatf("rand%0d_zero_before_done", t), z, 1);
      check_table($sformatf("final_rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
